// File: rtl/bist_signature_analyzer_if.sv
// Response-stream / status bundle between the CUT side, the test controller
// and the BIST signature analyzer.
interface bist_signature_analyzer_if #(
    parameter int unsigned RESP_W = 3,
    parameter int unsigned SIG_W  = 8
);
    logic              start;
    logic              resp_valid;
    logic [RESP_W-1:0] resp;
    logic              busy;
    logic              done;
    logic              pass;
    logic [SIG_W-1:0]  signature;
    logic [7:0]        pattern_cnt;

    modport master (
        output start, resp_valid, resp,
        input  busy, done, pass, signature, pattern_cnt
    );

    modport slave (
        input  start, resp_valid, resp,
        output busy, done, pass, signature, pattern_cnt
    );
endinterface

// File: rtl/bist_signature_analyzer.sv
// MISR-based output-response analyzer: compacts PATTERNS valid CUT responses
// into a Galois-form signature and compares it against GOLDEN.
module bist_signature_analyzer #(
    parameter int unsigned     RESP_W   = 3,
    parameter int unsigned     SIG_W    = 8,
    parameter logic [SIG_W-1:0] POLY    = 8'h1D,
    parameter logic [SIG_W-1:0] SEED    = 8'h00,
    parameter int unsigned     PATTERNS = 7,
    parameter logic [SIG_W-1:0] GOLDEN  = 8'h40
) (
    input  logic                     XLXN_21,
    input  logic                     XLXN_11,
    bist_signature_analyzer_if.slave bus
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERNS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPACT = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [SIG_W-1:0]   misr_next_c;

    // One MISR step: shift, fold the top bit back through POLY, inject response.
    assign misr_next_c = {sig_q[SIG_W-2:0], 1'b0}
                       ^ (sig_q[SIG_W-1] ? POLY : '0)
                       ^ SIG_W'(bus.resp);

    always_ff @(posedge XLXN_21 or posedge XLXN_11) begin
        if (XLXN_11) begin
            state_q <= S_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (bus.start) state_d = S_COMPACT;
            S_COMPACT:      if (bus.resp_valid && (cnt_q == LAST_CNT)) state_d = S_COMPARE;
            S_COMPARE:      state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Datapath and registered status; start in IDLE/DONE reloads the run.
    always_comb begin
        sig_d  = sig_q;
        cnt_d  = cnt_q;
        busy_d = (state_d == S_COMPACT) || (state_d == S_COMPARE);
        done_d = (state_d == S_DONE);
        pass_d = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    sig_d = SEED;
                    cnt_d = '0;
                end else begin
                    pass_d = pass_q;
                end
            end
            S_COMPACT: begin
                if (bus.resp_valid) begin
                    sig_d = misr_next_c;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COMPARE: pass_d = (sig_q == GOLDEN);
            default: ;
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.signature   = sig_q;
    assign bus.pattern_cnt = cnt_q;

endmodule
